// File: rtl/axi_pkg.sv
// Shared AXI write-master types: burst encodings, local response codes, FSM states
// and the AWLEN decode rule.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_SINGLE = 2'b00,
        BURST_INCR   = 2'b01,
        BURST_WRAP4  = 2'b10,
        BURST_INCR4  = 2'b11
    } burst_e;

    localparam logic [3:0] RESP_OKAY         = 4'h0;
    localparam logic [3:0] RESP_BADSIZE      = 4'hE;
    localparam logic [3:0] RESP_IDERR        = 4'hD;
    localparam logic [3:0] RESP_TIMEOUT_CODE = 4'hF;
    localparam logic [2:0] MAX_SIZE          = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_RESP = 3'd3,
        S_DONE = 3'd4
    } wr_state_e;

    // Fixed-length bursts ignore the requested length.
    function automatic logic [3:0] len_decode(input burst_e burst, input logic [3:0] len);
        logic [3:0] awlen;
        case (burst)
            BURST_SINGLE: awlen = 4'd0;
            BURST_INCR:   awlen = len;
            default:      awlen = 4'd3;
        endcase
        return awlen;
    endfunction

endpackage

// File: rtl/axi_write_master_if.sv
// AXI write address/data/response channels between the write master and the slave port.
interface axi_write_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8
) ();
    logic              AWVALID;
    logic              AWREADY;
    logic [ADDR_W-1:0] AWADDR;
    logic [3:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic [ID_W-1:0]   AWID;
    logic              WVALID;
    logic              WREADY;
    logic [DATA_W-1:0] WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic              WLAST;
    logic [ID_W-1:0]   WID;
    logic              BVALID;
    logic              BREADY;
    logic [3:0]        BRESP;
    logic [ID_W-1:0]   BID;

    modport master (
        output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
        input  AWREADY,
        output WVALID, WDATA, WSTRB, WLAST, WID,
        input  WREADY,
        input  BVALID, BRESP, BID,
        output BREADY
    );

    modport slave (
        input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID,
        output AWREADY,
        input  WVALID, WDATA, WSTRB, WLAST, WID,
        output WREADY,
        output BVALID, BRESP, BID,
        input  BREADY
    );
endinterface

// File: rtl/axi_write_master.sv
// Single-outstanding AXI write master: one command, AW beat, AWLEN+1 W beats,
// B response (or local error code) returned to the client.
module axi_write_master
    import axi_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int ID_W         = 8,
    parameter int RESP_TIMEOUT = 256
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [3:0]          cmd_len,
    input  logic [2:0]          cmd_size,
    input  logic [1:0]          cmd_burst,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    axi_write_master_if.master  axi,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [3:0]          rsp_resp,
    output logic [ID_W-1:0]     rsp_id
);

    localparam int TMO_W = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

    wr_state_e         state_r, state_s;
    logic              cmd_ready_r, cmd_ready_s;
    logic              awvalid_r, awvalid_s;
    logic [ADDR_W-1:0] awaddr_r, awaddr_s;
    logic [3:0]        awlen_r, awlen_s;
    logic [2:0]        awsize_r, awsize_s;
    logic [1:0]        awburst_r, awburst_s;
    logic [ID_W-1:0]   awid_r, awid_s;
    logic [3:0]        beat_r, beat_s;
    logic [TMO_W-1:0]  tmo_r, tmo_s;
    logic              bready_r, bready_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic [3:0]        rsp_resp_r, rsp_resp_s;
    logic [ID_W-1:0]   rsp_id_r, rsp_id_s;
    logic              in_data_s;
    logic              wbeat_s;
    logic              tmo_hit_s;

    assign in_data_s = (state_r == S_DATA);
    assign wbeat_s   = in_data_s && wd_valid && axi.WREADY;
    assign tmo_hit_s = (RESP_TIMEOUT != 0) && (tmo_r == TMO_W'(RESP_TIMEOUT - 1));

    // Next-state and next-register values for the whole command lifecycle.
    always_comb begin
        state_s     = state_r;
        cmd_ready_s = cmd_ready_r;
        awvalid_s   = awvalid_r;
        awaddr_s    = awaddr_r;
        awlen_s     = awlen_r;
        awsize_s    = awsize_r;
        awburst_s   = awburst_r;
        awid_s      = awid_r;
        beat_s      = beat_r;
        tmo_s       = tmo_r;
        bready_s    = bready_r;
        rsp_valid_s = rsp_valid_r;
        rsp_resp_s  = rsp_resp_r;
        rsp_id_s    = rsp_id_r;
        case (state_r)
            S_IDLE: begin
                cmd_ready_s = 1'b1;
                if (cmd_valid && cmd_ready_r) begin
                    cmd_ready_s = 1'b0;
                    awaddr_s    = cmd_addr;
                    awlen_s     = len_decode(burst_e'(cmd_burst), cmd_len);
                    awsize_s    = cmd_size;
                    awburst_s   = cmd_burst;
                    awid_s      = cmd_id;
                    beat_s      = 4'd0;
                    if (cmd_size > MAX_SIZE) begin
                        state_s     = S_DONE;
                        rsp_valid_s = 1'b1;
                        rsp_resp_s  = RESP_BADSIZE;
                        rsp_id_s    = cmd_id;
                    end else begin
                        state_s   = S_ADDR;
                        awvalid_s = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ADDR: begin
                if (awvalid_r && axi.AWREADY) begin
                    awvalid_s = 1'b0;
                    state_s   = S_DATA;
                end else begin
                    state_s = S_ADDR;
                end
            end
            S_DATA: begin
                if (wbeat_s && (beat_r == awlen_r)) begin
                    state_s  = S_RESP;
                    bready_s = 1'b1;
                    tmo_s    = '0;
                end else if (wbeat_s) begin
                    beat_s = beat_r + 4'd1;
                end else begin
                    state_s = S_DATA;
                end
            end
            S_RESP: begin
                if (bready_r && axi.BVALID) begin
                    bready_s    = 1'b0;
                    state_s     = S_DONE;
                    rsp_valid_s = 1'b1;
                    rsp_resp_s  = (axi.BID != awid_r) ? RESP_IDERR : axi.BRESP;
                    rsp_id_s    = awid_r;
                end else if (tmo_hit_s) begin
                    // Give up on the slave; any later BVALID lands in S_DONE/S_IDLE and is ignored.
                    bready_s    = 1'b0;
                    state_s     = S_DONE;
                    rsp_valid_s = 1'b1;
                    rsp_resp_s  = RESP_TIMEOUT_CODE;
                    rsp_id_s    = awid_r;
                end else begin
                    tmo_s = tmo_r + TMO_W'(1'b1);
                end
            end
            S_DONE: begin
                if (rsp_valid_r && rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    cmd_ready_s = 1'b1;
                    state_s     = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s     = S_IDLE;
                cmd_ready_s = 1'b0;
                awvalid_s   = 1'b0;
                bready_s    = 1'b0;
                rsp_valid_s = 1'b0;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset abandons any partial burst.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r     <= S_IDLE;
            cmd_ready_r <= 1'b0;
            awvalid_r   <= 1'b0;
            awaddr_r    <= '0;
            awlen_r     <= 4'd0;
            awsize_r    <= 3'd0;
            awburst_r   <= 2'd0;
            awid_r      <= '0;
            beat_r      <= 4'd0;
            tmo_r       <= '0;
            bready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_resp_r  <= 4'd0;
            rsp_id_r    <= '0;
        end else begin
            state_r     <= state_s;
            cmd_ready_r <= cmd_ready_s;
            awvalid_r   <= awvalid_s;
            awaddr_r    <= awaddr_s;
            awlen_r     <= awlen_s;
            awsize_r    <= awsize_s;
            awburst_r   <= awburst_s;
            awid_r      <= awid_s;
            beat_r      <= beat_s;
            tmo_r       <= tmo_s;
            bready_r    <= bready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_resp_r  <= rsp_resp_s;
            rsp_id_r    <= rsp_id_s;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign axi.AWVALID = awvalid_r;
    assign axi.AWADDR  = awaddr_r;
    assign axi.AWLEN   = awlen_r;
    assign axi.AWSIZE  = awsize_r;
    assign axi.AWBURST = awburst_r;
    assign axi.AWID    = awid_r;
    // The W channel is a straight pass-through of the local data stream while in S_DATA.
    assign axi.WVALID  = in_data_s && wd_valid;
    assign wd_ready    = in_data_s && axi.WREADY;
    assign axi.WDATA   = in_data_s ? wd_data : '0;
    assign axi.WSTRB   = in_data_s ? wd_strb : '0;
    assign axi.WLAST   = in_data_s && (beat_r == awlen_r);
    assign axi.WID     = in_data_s ? awid_r : '0;
    assign axi.BREADY  = bready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_resp    = rsp_resp_r;
    assign rsp_id      = rsp_id_r;

endmodule

// File: tb/tb_axi_write_master.sv
// Directed + randomized bench for axi_write_master with a transaction-level
// reference model and a cycle-by-cycle slave/client driver.
module tb_axi_write_master;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = 32'd0;
    logic [3:0]  cmd_len = 4'd0;
    logic [2:0]  cmd_size = 3'd0;
    logic [1:0]  cmd_burst = 2'd0;
    logic [7:0]  cmd_id = 8'd0;
    logic        wd_valid = 1'b0;
    logic        wd_ready;
    logic [31:0] wd_data = 32'd0;
    logic [3:0]  wd_strb = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_resp;
    logic [7:0]  rsp_id;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    axi_write_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(8)) axi ();

    axi_write_master #(.ADDR_W(32), .DATA_W(32), .ID_W(8), .RESP_TIMEOUT(256)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .axi(axi.master),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_id(rsp_id)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_slave();
        axi.AWREADY = 1'b0;
        axi.WREADY  = 1'b0;
        axi.BVALID  = 1'b0;
        axi.BRESP   = 4'd0;
        axi.BID     = 8'd0;
        wd_valid    = 1'b0;
        cmd_valid   = 1'b0;
        rsp_ready   = 1'b0;
    endtask

    // One full transaction: issue, drive slave/client, compare against the model.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] id, input int aw_delay,
                           input bit gaps, input logic [3:0] bresp, input logic [7:0] bid,
                           input bit no_b, input int b_delay, input int rst_beat);
        logic [31:0] data_a [16];
        logic [3:0]  strb_a [16];
        bit          bad, acc, aw_done, w_done, b_done, got_rsp, in_data;
        int          exp_len, n_beats, aw_seen, beats, b_wait, bready_hi, rsp_cyc, d;
        logic [3:0]  exp_resp;

        bad      = (size > 3'd2);
        exp_len  = (burst == 2'b00) ? 0 : (burst == 2'b01) ? int'(len) : 3;
        n_beats  = bad ? 0 : exp_len + 1;
        exp_resp = bad ? 4'hE : no_b ? 4'hF : (bid != id) ? 4'hD : bresp;
        for (int i = 0; i < 16; i++) begin
            data_a[i] = $urandom;
            strb_a[i] = 4'($urandom);
        end
        acc = 1'b0; aw_done = 1'b0; w_done = 1'b0; b_done = 1'b0; got_rsp = 1'b0;
        aw_seen = 0; beats = 0; b_wait = 0; bready_hi = 0; rsp_cyc = -1;

        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge ACLK);
            cmd_valid = 1'b1; cmd_addr = addr; cmd_len = len; cmd_size = size;
            cmd_burst = burst; cmd_id = id;
            #1;
            if (cmd_ready) acc = 1'b1;
        end
        check("cmd_accept", 64'(acc), 64'd1);

        for (int c = 0; c < 600 && acc && !got_rsp; c++) begin
            @(negedge ACLK);
            cmd_valid   = 1'b0;
            axi.AWREADY = (aw_seen >= aw_delay);
            axi.WREADY  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            wd_valid    = (beats < n_beats) && (!gaps || ($urandom_range(0, 2) != 0));
            wd_data     = data_a[beats % 16];
            wd_strb     = strb_a[beats % 16];
            axi.BVALID  = w_done && !b_done && !no_b && (b_wait >= b_delay);
            axi.BRESP   = bresp;
            axi.BID     = bid;
            if (w_done) b_wait++;
            in_data = aw_done && !w_done;
            #1;
            if (rst_beat >= 0 && aw_done && beats == rst_beat) begin
                ARESETn = 1'b0;
                #1;
                check("rst_awvalid", 64'(axi.AWVALID), 64'd0);
                check("rst_wvalid", 64'(axi.WVALID), 64'd0);
                check("rst_bready", 64'(axi.BREADY), 64'd0);
                check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
                check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
                clear_slave();
                @(negedge ACLK);
                ARESETn = 1'b1;
                return;
            end
            if (bad) check("bad_no_aw", 64'(axi.AWVALID), 64'd0);
            check("wvalid_pass", 64'(axi.WVALID), 64'(in_data && wd_valid));
            check("wd_ready_pass", 64'(wd_ready), 64'(in_data && axi.WREADY));
            if (axi.AWVALID) begin
                check("aw_addr", 64'(axi.AWADDR), 64'(addr));
                check("aw_len", 64'(axi.AWLEN), 64'(exp_len));
                check("aw_size_burst_id", {axi.AWSIZE, axi.AWBURST, axi.AWID}, {size, burst, id});
                aw_seen++;
                if (axi.AWREADY) aw_done = 1'b1;
            end
            if (axi.WVALID && axi.WREADY) begin
                check("w_data", 64'(axi.WDATA), 64'(data_a[beats % 16]));
                check("w_strb_id", {axi.WSTRB, axi.WID}, {strb_a[beats % 16], id});
                check("w_last", 64'(axi.WLAST), 64'(beats == exp_len));
                beats++;
                if (beats == n_beats) w_done = 1'b1;
            end
            if (axi.BREADY) bready_hi++;
            if (axi.BVALID && axi.BREADY) b_done = 1'b1;
            if (rsp_valid) begin
                got_rsp = 1'b1;
                rsp_cyc = c;
                check("rsp_resp", 64'(rsp_resp), 64'(exp_resp));
                check("rsp_id", 64'(rsp_id), 64'(id));
            end
        end
        check("rsp_seen", 64'(got_rsp), 64'd1);
        if (!got_rsp) begin
            clear_slave();
            return;
        end
        check("beat_count", 64'(beats), 64'(n_beats));
        if (bad) check("bad_latency", 64'(rsp_cyc), 64'd0);
        else check("aw_cycles", 64'(aw_seen), 64'(aw_delay + 1));
        if (no_b && !bad) check("tmo_cycles", 64'(bready_hi), 64'd256);

        d = $urandom_range(0, 2);
        for (int i = 0; i < d; i++) begin
            @(negedge ACLK);
            axi.BVALID = no_b;
            axi.BID    = bid;
            #1;
            check("rsp_hold", {rsp_valid, rsp_resp, rsp_id}, {1'b1, exp_resp, id});
            if (no_b) check("tmo_bready_low", 64'(axi.BREADY), 64'd0);
        end
        @(negedge ACLK);
        axi.BVALID = 1'b0;
        rsp_ready  = 1'b1;
        #1;
        check("rsp_before_ack", {rsp_valid, rsp_resp}, {1'b1, exp_resp});
        @(negedge ACLK);
        rsp_ready = 1'b0;
        #1;
        check("rsp_dropped", 64'(rsp_valid), 64'd0);
        check("back_to_idle", 64'(cmd_ready), 64'd1);
        clear_slave();
    endtask

    initial begin
        logic [7:0] rid;
        clear_slave();
        ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        #1;
        check("reset_valids", {axi.AWVALID, axi.WVALID, axi.BREADY, rsp_valid, cmd_ready, wd_ready},
              6'd0);
        check("reset_payload", {axi.AWADDR, axi.AWLEN, rsp_resp, rsp_id}, 48'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        #1;
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);

        // INCR len=2, AWREADY held off 3 cycles, OKAY response.
        run_txn(32'h100, 4'd2, 3'd2, 2'b01, 8'h12, 3, 1'b0, 4'h0, 8'h12, 1'b0, 1, -1);
        // WRAP4 ignores cmd_len; SINGLE is one beat.
        run_txn(32'h208, 4'd9, 3'd2, 2'b10, 8'h21, 0, 1'b0, 4'h0, 8'h21, 1'b0, 0, -1);
        run_txn(32'h30C, 4'd7, 3'd1, 2'b00, 8'h33, 1, 1'b0, 4'h2, 8'h33, 1'b0, 2, -1);
        // INCR len=15 with random gaps on both sides of the data stream.
        run_txn(32'h400, 4'd15, 3'd2, 2'b01, 8'h44, 2, 1'b1, 4'h0, 8'h44, 1'b0, 0, -1);
        // Illegal size: no bus traffic, local error code.
        run_txn(32'h500, 4'd3, 3'd3, 2'b01, 8'h50, 0, 1'b0, 4'h0, 8'h50, 1'b0, 0, -1);
        // BID mismatch.
        run_txn(32'h600, 4'd1, 3'd2, 2'b01, 8'h12, 0, 1'b0, 4'h0, 8'h55, 1'b0, 0, -1);
        // No BVALID: internal timeout, stray BVALID afterwards.
        run_txn(32'h700, 4'd0, 3'd0, 2'b11, 8'h77, 0, 1'b0, 4'h0, 8'h77, 1'b1, 0, -1);
        // Reset during beat 2 of 4, then a clean transaction.
        run_txn(32'h800, 4'd0, 3'd2, 2'b11, 8'h88, 0, 1'b0, 4'h0, 8'h88, 1'b0, 0, 1);
        run_txn(32'h900, 4'd3, 3'd2, 2'b01, 8'h99, 1, 1'b0, 4'h1, 8'h99, 1'b0, 1, -1);

        for (int t = 0; t < 6; t++) begin
            rid = 8'($urandom);
            run_txn($urandom, 4'($urandom), 3'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                    rid, $urandom_range(0, 3), 1'b1, 4'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? (rid ^ 8'h01) : rid, 1'b0,
                    $urandom_range(0, 3), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
